// File: rtl/calc1_pkg.sv
// Shared command/response codes and FSM state encoding for the calc1 responder.
package calc1_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPND2 = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 execute stage: result and response code from a latched
// command and its two operands (big-endian bit numbering, bit 0 is MSB).
module calc1_alu
  import calc1_pkg::*;
(
  input  logic [0:3]  cmd,
  input  logic [0:31] op1,
  input  logic [0:31] op2,
  output logic [0:31] result,
  output logic [0:1]  resp
);

  logic [0:32] sum;
  logic [4:0]  shamt;

  // sum[0] is the carry out of the 32-bit add
  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign shamt = op2[27:31];

  always_comb begin
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum[0]) begin
          resp   = RESP_OK;
          result = sum[1:32];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp   = RESP_OK;
          result = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp   = RESP_OK;
        result = op1 << shamt;
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = op1 >> shamt;
      end
      default: begin
        resp   = RESP_ERR;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: captures command + operand 1, then operand 2,
// waits out LATENCY and presents a one-cycle registered response.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [0:1]        out_resp,
  output logic [0:DATA_W-1] out_data
);

  state_t            state_reg, state_next;
  logic [0:3]        cmd_reg, cmd_next;
  logic [0:DATA_W-1] op1_reg, op1_next;
  logic [0:DATA_W-1] op2_reg, op2_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [0:1]        resp_reg, resp_next;
  logic [0:DATA_W-1] data_reg, data_next;

  logic [0:DATA_W-1] alu_op2;
  logic [0:DATA_W-1] alu_result;
  logic [0:1]        alu_resp;

  // With LATENCY = 1 the result is registered on the operand-2 edge itself,
  // so operand 2 has to come straight from the bus.
  assign alu_op2 = (LATENCY == 1 && state_reg == ST_OPND2) ? req_data_in : op2_reg;

  calc1_alu u_alu (
    .cmd    (cmd_reg),
    .op1    (op1_reg),
    .op2    (alu_op2),
    .result (alu_result),
    .resp   (alu_resp)
  );

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= CMD_NOP;
      op1_reg   <= '0;
      op2_reg   <= '0;
      cnt_reg   <= '0;
      resp_reg  <= RESP_NONE;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      op1_reg   <= op1_next;
      op2_reg   <= op2_next;
      cnt_reg   <= cnt_next;
      resp_reg  <= resp_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    cnt_next   = cnt_reg;
    resp_next  = RESP_NONE;
    data_next  = '0;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        if (req_cmd_in != CMD_NOP) begin
          cmd_next   = req_cmd_in;
          op1_next   = req_data_in;
          state_next = ST_OPND2;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_OPND2: begin
        op2_next = req_data_in;
        cnt_next = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_next = ST_RESP;
          resp_next  = alu_resp;
          data_next  = alu_result;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // counter reaches 0 on this edge: result goes out next cycle
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_RESP;
          resp_next  = alu_resp;
          data_next  = alu_result;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign out_resp = resp_reg;
  assign out_data = data_reg;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Self-checking bench: directed calc1 scenarios followed by random traffic,
// checked every cycle against a cycle-indexed schedule of expected responses.
module tb_calc1_port_responder;

  localparam int LAT = 3;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;

  always #5 c_clk = ~c_clk;

  calc1_port_responder #(.LATENCY(LAT), .DATA_W(32)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  // expected outputs keyed by cycle number; absent key means all-zero
  logic [1:0]  exp_resp [int];
  logic [31:0] exp_data [int];

  int          acc_cycle  = -100;
  int          free_cycle = 0;
  logic [3:0]  m_cmd;
  logic [31:0] m_op1;

  function automatic void ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                   input logic [31:0] b, output logic [1:0] r,
                                   output logic [31:0] d);
    longint unsigned s;
    int unsigned sh;
    r = 2'd2;
    d = 32'd0;
    sh = int'(b) & 31;
    case (int'(cmd))
      1: begin
        s = longint'(a) + longint'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
      end
      2: if (a >= b) begin r = 2'd1; d = a - b; end
      5: begin r = 2'd1; d = a << sh; end
      6: begin r = 2'd1; d = a >> sh; end
      default: begin r = 2'd2; d = 32'd0; end
    endcase
  endfunction

  task automatic tick(input logic [3:0] cmd, input logic [31:0] data, input logic rst);
    logic [1:0]  er;
    logic [31:0] ed;
    logic [1:0]  r;
    logic [31:0] d;
    if (check_en) begin
      er = exp_resp.exists(cyc) ? exp_resp[cyc] : 2'd0;
      ed = exp_data.exists(cyc) ? exp_data[cyc] : 32'd0;
      total++;
      assert (out_resp === er) else begin
        bad++;
        $error("FAIL resp cyc=%0d got=%0h exp=%0h", cyc, out_resp, er);
      end
      total++;
      assert (out_data === ed) else begin
        bad++;
        $error("FAIL data cyc=%0d got=%08h exp=%08h", cyc, out_data, ed);
      end
    end
    reset       = rst;
    req_cmd_in  = cmd;
    req_data_in = data;
    if (rst) begin
      for (int k = cyc + 1; k <= cyc + LAT + 2; k++) begin
        exp_resp.delete(k);
        exp_data.delete(k);
      end
      acc_cycle  = -100;
      free_cycle = cyc + 1;
    end else if (cyc == acc_cycle + 1) begin
      ref_calc(m_cmd, m_op1, data, r, d);
      exp_resp[cyc + LAT] = r;
      exp_data[cyc + LAT] = d;
      $display("req cyc=%0d cmd=%0d op1=%08h op2=%08h -> resp=%0d data=%08h at cyc=%0d",
               acc_cycle, m_cmd, m_op1, data, r, d, cyc + LAT);
    end else if (cmd != 4'd0 && cyc >= free_cycle) begin
      m_cmd      = cmd;
      m_op1      = data;
      acc_cycle  = cyc;
      free_cycle = cyc + 1 + LAT;
    end
    @(posedge c_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'd0, 32'd0, 1'b0);
  endtask

  task automatic req(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    tick(cmd, a, 1'b0);
    tick(4'd0, b, 1'b0);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 40));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    req_cmd_in = 4'd0;
    req_data_in = 32'd0;
    tick(4'd0, 32'd0, 1'b1);
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) tick(4'd0, 32'd0, 1'b1);
    idle(3);

    req(4'd1, 32'h0000_0001, 32'h1FFF_FFFF); idle(4);
    req(4'd1, 32'hFFFF_FFFF, 32'h0000_0001); idle(2);
    req(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF); idle(5);
    req(4'd2, 32'h1, 32'hF); idle(3);
    req(4'd2, 32'h5, 32'h5); idle(3);
    req(4'd5, 32'h1, 32'h0000_0024); idle(3);
    req(4'd6, 32'h8000_0000, 32'd31); idle(3);
    req(4'd3, 32'h1234_5678, 32'h1); idle(3);
    req(4'd4, 32'h1, 32'h1); idle(3);
    req(4'd1, 32'h10, 32'h20);
    req(4'd1, 32'h30, 32'h40); idle(4);
    req(4'd1, 32'h7, 32'h8);
    tick(4'd0, 32'd0, 1'b1); idle(5);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      tick(c, rand_data(), ($urandom_range(0, 59) == 0));
    end
    idle(LAT + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc1_port_responder.md
Name: calc1_port_responder

Overview:
- Single-port responder for the calc1 request/response protocol: accepts a two-cycle command/operand request on one requester port, executes it, and returns a one-cycle response code plus result data.
- Used as the building block for a calc1 port slice, and as a reference responder the verification team can compare against the calc1 black box port-by-port.
- All data buses use big-endian bit numbering: [0:31], bit 0 is MSB.

Parameters:
- LATENCY, 3, cycles from operand-2 cycle to response cycle; legal range 1..15.
- DATA_W, 32, operand/result width; only 32 is supported.

Ports:
- c_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_cmd_in  input  [0:3]  command. 0 = no-op, 1 = add, 2 = subtract, 5 = shift left, 6 = shift right; all other values are invalid.
- req_data_in  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle.
- out_resp  output  [0:1]  response code. 0 = none, 1 = success, 2 = overflow/underflow/invalid command, 3 = never driven.
- out_data  output  [0:31]  result; nonzero only in the response cycle with out_resp = 1.

Behaviour:
- Reset: when reset = 1 at an edge, the state goes to IDLE and all captured operands and the counter clear. Both outputs read 0 from the next cycle. Reset mid-request discards the request; no response is ever issued for it.
- States:
  - IDLE: a nonzero req_cmd_in at edge N latches cmd and operand 1, then → OPND2.
  - OPND2: latch req_data_in as operand 2 at edge N+1; req_cmd_in is ignored in this cycle. Then → EXEC and load the counter with LATENCY-1.
  - EXEC: decrement the counter; at 0, register the result → RESP.
  - RESP: outputs are valid for exactly one cycle. Behaves as IDLE for acceptance: a nonzero cmd here is captured, otherwise → IDLE.
- Timing: with the command in cycle N, the response is visible during cycle N+1+LATENCY only; outputs are 0 in every other cycle. For LATENCY = 1, EXEC is skipped (OPND2 → RESP).
- A nonzero cmd in OPND2 or EXEC is dropped silently; no response is issued for it.
- Add: 33-bit sum. If carry out = 1 → resp 2, data 0; else resp 1, data = sum[31:0].
- Subtract: if op2 > op1 (unsigned) → resp 2, data 0; else resp 1, data = op1 - op2. An equal result of 0 is success.
- Shift left/right: logical shift of op1 by op2 low 5 bits (bits [27:31]); op2 upper bits are ignored. Always resp 1; a zero result is legal.
- Invalid cmd (3, 4, 7-15): still consumes the operand-2 cycle and the full latency, then resp 2, data 0.
- Result is computed combinationally from the latched operands and registered on entry to RESP. Outputs are registered; there is no combinational input→output path.

Decomposition:
- Package calc1_pkg holds:
  - cmd constants: CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6.
  - resp constants: RESP_NONE = 0, RESP_OK = 1, RESP_ERR = 2.
  - state encoding for IDLE/OPND2/EXEC/RESP.
- One combinational sub-module, calc1_alu, takes (cmd, op1, op2) and produces (result[0:31], resp[0:1]). The FSM and counter stay in calc1_port_responder.

Test Plan:
- Reset held 4 cycles, then released → out_resp = 0 and out_data = 0 every cycle; no spurious response.
- Add 0000_0001h + 1FFF_FFFFh (cmd in cycle N) → cycle N+4: resp 1, data 2000_0000h. Outputs are 0 in cycles N+3 and N+5.
- Add FFFF_FFFFh + 1 → resp 2, data 0. Then add 1FFF_FFFFh + 1FFF_FFFFh issued in the RESP cycle → resp 1, data 3FFF_FFFEh at the correct later cycle.
- Subtract 1 - Fh → resp 2, data 0. Subtract 5 - 5 → resp 1, data 0.
- Shift left 1 by 0000_0024h (effective shift 4) → data 10h. Shift right 8000_0000h by 31 → data 1. cmd 3 and cmd 4 → resp 2 after full latency.
- Back-to-back cmd 1 in cycles N and N+2 → only the first gets a response; the second is dropped. Reset asserted in cycle N+2 of a new request → no response, outputs 0.
